// File: rtl/mem_bus_arbiter.sv
// Two-port start/done arbiter for the shared 32-bit memory bus.
// Port 0 is CPU data memory, port 1 is instruction fetch; a watchdog aborts transfers whose bus_done never comes.
module mem_bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_data,
  input  logic        r0_we,
  input  logic        r0_start,
  output logic [31:0] r0_q,
  output logic        r0_done,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_data,
  input  logic        r1_we,
  input  logic        r1_start,
  output logic [31:0] r1_q,
  output logic        r1_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam bit               WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [CNT_W-1:0] wd_cnt_q;
  logic             busy, req_any, winner, wd_fire, ok_done, finish;

  // A completing bus_done always beats the watchdog in the same cycle.
  always_comb begin
    busy    = (state_q == BUSY);
    req_any = r0_start | r1_start;
    ok_done = busy && bus_done;
    wd_fire = WD_EN && busy && !bus_done && (wd_cnt_q == WD_LAST);
    finish  = ok_done || wd_fire;
    if (r0_start && r1_start) winner = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    else                      winner = r1_start;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = BUSY;
      BUSY:    if (finish)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_start = busy && !bus_done;
    r0_done   = finish && !grant;
    r1_done   = finish && grant;
    r0_q      = (ok_done && !grant) ? bus_q : 32'd0;
    r1_q      = (ok_done && grant)  ? bus_q : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request fields are captured only at the grant edge and then held for the whole transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant        <= 1'b0;
      last_grant_q <= 1'b1;
      bus_addr     <= 32'd0;
      bus_data     <= 32'd0;
      bus_we       <= 1'b0;
      wd_cnt_q     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (!busy && req_any) begin
        grant    <= winner;
        bus_addr <= winner ? r1_addr : r0_addr;
        bus_data <= winner ? r1_data : r0_data;
        bus_we   <= winner ? r1_we   : r0_we;
        wd_cnt_q <= '0;
      end
      if (finish)            last_grant_q <= grant;
      else if (busy && WD_EN) wd_cnt_q    <= wd_cnt_q + CNT_W'(1);
      if (wd_fire)           timeout_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share one stimulus stream
// and are each compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
  localparam int TO = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] r0_addr, r0_data, r1_addr, r1_data, bus_q;
  logic        r0_we, r1_we, r0_start, r1_start, bus_done;

  logic [31:0] o_r0_q [2];
  logic [31:0] o_r1_q [2];
  logic [31:0] o_bus_addr [2];
  logic [31:0] o_bus_data [2];
  logic        o_r0_done [2];
  logic        o_r1_done [2];
  logic        o_bus_we [2];
  logic        o_bus_start [2];
  logic        o_grant [2];
  logic        o_err [2];

  mem_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO), .CNT_W(CW)) dut_rr (
    .clk(clk), .reset(reset),
    .r0_addr(r0_addr), .r0_data(r0_data), .r0_we(r0_we), .r0_start(r0_start),
    .r0_q(o_r0_q[0]), .r0_done(o_r0_done[0]),
    .r1_addr(r1_addr), .r1_data(r1_data), .r1_we(r1_we), .r1_start(r1_start),
    .r1_q(o_r1_q[0]), .r1_done(o_r1_done[0]),
    .bus_addr(o_bus_addr[0]), .bus_data(o_bus_data[0]), .bus_we(o_bus_we[0]),
    .bus_start(o_bus_start[0]), .bus_q(bus_q), .bus_done(bus_done),
    .grant(o_grant[0]), .timeout_err(o_err[0])
  );

  mem_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO), .CNT_W(CW)) dut_fp (
    .clk(clk), .reset(reset),
    .r0_addr(r0_addr), .r0_data(r0_data), .r0_we(r0_we), .r0_start(r0_start),
    .r0_q(o_r0_q[1]), .r0_done(o_r0_done[1]),
    .r1_addr(r1_addr), .r1_data(r1_data), .r1_we(r1_we), .r1_start(r1_start),
    .r1_q(o_r1_q[1]), .r1_done(o_r1_done[1]),
    .bus_addr(o_bus_addr[1]), .bus_data(o_bus_data[1]), .bus_we(o_bus_we[1]),
    .bus_start(o_bus_start[1]), .bus_q(bus_q), .bus_done(bus_done),
    .grant(o_grant[1]), .timeout_err(o_err[1])
  );

  // One open transaction per instance: who owns it, how long it has run, what was captured.
  typedef struct {
    logic        busy;
    logic        owner;
    logic        last;
    int          age;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } model_t;

  model_t ms [2];
  bit     rr_of [2] = '{1'b1, 1'b0};
  int     checks = 0;
  int     passed = 0;
  int     failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    ms[k].busy = 1'b0; ms[k].owner = 1'b0; ms[k].last = 1'b1; ms[k].age = 0;
    ms[k].err = 1'b0;  ms[k].addr = 32'd0;  ms[k].data = 32'd0; ms[k].we = 1'b0;
  endtask

  function automatic logic ends_now(input int k);
    return ms[k].busy && (bus_done || ms[k].age == TO - 1);
  endfunction

  task automatic model_step(input int k);
    logic w;
    if (reset) model_reset(k);
    else if (ms[k].busy) begin
      if (ends_now(k)) begin
        if (!bus_done) ms[k].err = 1'b1;
        ms[k].busy = 1'b0;
        ms[k].last = ms[k].owner;
      end else ms[k].age++;
    end else if (r0_start || r1_start) begin
      if (r0_start && r1_start) w = rr_of[k] ? !ms[k].last : 1'b0;
      else                      w = r1_start;
      ms[k].busy  = 1'b1;
      ms[k].owner = w;
      ms[k].age   = 0;
      ms[k].addr  = w ? r1_addr : r0_addr;
      ms[k].data  = w ? r1_data : r0_data;
      ms[k].we    = w ? r1_we   : r0_we;
    end
  endtask

  task automatic checkOutput(input int k);
    logic  fin, ok;
    string p;
    fin = ends_now(k);
    ok  = ms[k].busy && bus_done;
    p   = (k == 0) ? "rr" : "fp";
    chk($sformatf("%s.bus_start", p), {31'd0, o_bus_start[k]}, {31'd0, ms[k].busy && !bus_done});
    chk($sformatf("%s.r0_done", p), {31'd0, o_r0_done[k]}, {31'd0, fin && !ms[k].owner});
    chk($sformatf("%s.r1_done", p), {31'd0, o_r1_done[k]}, {31'd0, fin && ms[k].owner});
    chk($sformatf("%s.r0_q", p), o_r0_q[k], (ok && !ms[k].owner) ? bus_q : 32'd0);
    chk($sformatf("%s.r1_q", p), o_r1_q[k], (ok && ms[k].owner) ? bus_q : 32'd0);
    chk($sformatf("%s.grant", p), {31'd0, o_grant[k]}, {31'd0, ms[k].owner});
    chk($sformatf("%s.bus_addr", p), o_bus_addr[k], ms[k].addr);
    chk($sformatf("%s.bus_data", p), o_bus_data[k], ms[k].data);
    chk($sformatf("%s.bus_we", p), {31'd0, o_bus_we[k]}, {31'd0, ms[k].we});
    chk($sformatf("%s.timeout_err", p), {31'd0, o_err[k]}, {31'd0, ms[k].err});
  endtask

  task automatic applyStimulus(input int port, input logic start, input logic [31:0] addr,
                               input logic [31:0] data, input logic we);
    if (port == 0) begin
      r0_start = start; r0_addr = addr; r0_data = data; r0_we = we;
    end else begin
      r1_start = start; r1_addr = addr; r1_data = data; r1_we = we;
    end
  endtask

  task automatic set_bus(input logic done, input logic [31:0] q);
    bus_done = done;
    bus_q    = q;
  endtask

  // Compare mid-cycle, advance the model with the inputs that the coming edge will see.
  task automatic run_cycle();
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycle(input bit allow_new, input bit allow_reset);
    logic fin;
    reset = allow_reset && ($urandom_range(0, 99) == 0);
    if (allow_new && !r0_start && $urandom_range(0, 2) == 0)
      applyStimulus(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    if (allow_new && !r1_start && $urandom_range(0, 2) == 0)
      applyStimulus(1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    if (ms[0].busy) set_bus($urandom_range(0, 4) == 0, $urandom);
    else            set_bus(allow_new && ($urandom_range(0, 9) == 0), $urandom);
    fin = ends_now(0);
    if (fin && !ms[0].owner) r0_start = 1'b0;
    if (fin && ms[0].owner)  r1_start = 1'b0;
    run_cycle();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && (r0_start || r1_start || ms[0].busy); i++) random_cycle(1'b0, 1'b0);
    set_bus(1'b0, 32'd0);
    #1;
    chk(tag, {30'd0, o_bus_start[0], r0_start | r1_start}, 32'd0);
  endtask

  initial begin
    logic exp_rr;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0);
    set_bus(1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset(0);
    model_reset(1);
    run_cycle();
    reset = 1'b0;

    $display("[TB] single read on port 0");
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'd0, 1'b0);
    run_cycle();
    #1 chk("t1.bus_addr", o_bus_addr[0], 32'h0000_0100);
    repeat (3) run_cycle();
    set_bus(1'b1, 32'hDEAD_BEEF);
    r0_start = 1'b0;
    #1;
    chk("t1.r0_done", {31'd0, o_r0_done[0]}, 32'd1);
    chk("t1.r0_q", o_r0_q[0], 32'hDEAD_BEEF);
    chk("t1.r1_done", {31'd0, o_r1_done[0]}, 32'd0);
    chk("t1.bus_start_done", {31'd0, o_bus_start[0]}, 32'd0);
    run_cycle();
    set_bus(1'b0, 32'd0);
    run_cycle();

    $display("[TB] contention after reset");
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 32'h0000_00A0, 32'h1, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_00B0, 32'h2, 1'b0);
    run_cycle();
    #1 chk("t2.rr_first", {31'd0, o_grant[0]}, 32'd0);
    run_cycle();
    set_bus(1'b1, 32'h1111_1111);
    r0_start = 1'b0;
    run_cycle();
    set_bus(1'b0, 32'd0);
    run_cycle();
    #1;
    chk("t2.rr_second", {31'd0, o_grant[0]}, 32'd1);
    chk("t2.rr_second_addr", o_bus_addr[0], 32'h0000_00B0);
    set_bus(1'b1, 32'h2222_2222);
    r1_start = 1'b0;
    run_cycle();
    set_bus(1'b0, 32'd0);
    applyStimulus(0, 1'b1, 32'h0000_00C0, 32'h3, 1'b1);
    applyStimulus(1, 1'b1, 32'h0000_00D0, 32'h4, 1'b1);
    drain("t2.drain_bound");

    $display("[TB] continuous contention");
    applyStimulus(0, 1'b1, 32'h0000_0300, 32'h5, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_0310, 32'h6, 1'b0);
    exp_rr = !ms[0].last;
    for (int t = 0; t < 4; t++) begin
      run_cycle();
      #1;
      chk("t3.fp_grant", {31'd0, o_grant[1]}, 32'd0);
      chk("t3.rr_grant", {31'd0, o_grant[0]}, {31'd0, exp_rr});
      exp_rr = !exp_rr;
      set_bus(1'b1, $urandom);
      run_cycle();
      set_bus(1'b0, 32'd0);
    end
    r0_start = 1'b0;
    r1_start = 1'b0;
    drain("t3.drain_bound");

    $display("[TB] captured write held through BUSY");
    applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1);
    run_cycle();
    applyStimulus(1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1'b0);
    run_cycle();
    #1;
    chk("t4.bus_data", o_bus_data[0], 32'h1234_5678);
    chk("t4.bus_we", {31'd0, o_bus_we[0]}, 32'd1);
    chk("t4.bus_addr", o_bus_addr[1], 32'h0000_0020);
    r1_start = 1'b0;
    repeat (2) run_cycle();
    set_bus(1'b1, 32'h0000_0005);
    #1 chk("t4.r1_done_after_drop", {31'd0, o_r1_done[0]}, 32'd1);
    run_cycle();
    set_bus(1'b0, 32'd0);

    $display("[TB] watchdog");
    applyStimulus(0, 1'b1, 32'h0000_0500, 32'd0, 1'b0);
    run_cycle();
    repeat (TO - 1) run_cycle();
    r0_start = 1'b0;
    #1;
    chk("t5.r0_done", {31'd0, o_r0_done[0]}, 32'd1);
    chk("t5.r0_q", o_r0_q[0], 32'd0);
    run_cycle();
    #1 chk("t5.err_set", {31'd0, o_err[0]}, 32'd1);
    set_bus(1'b1, 32'hBAD0_BAD0);
    #1;
    chk("t5.stray_r0_done", {31'd0, o_r0_done[0]}, 32'd0);
    chk("t5.stray_r1_done", {31'd0, o_r1_done[1]}, 32'd0);
    run_cycle();
    set_bus(1'b0, 32'd0);
    run_cycle();
    applyStimulus(1, 1'b1, 32'h0000_0600, 32'h9, 1'b1);
    repeat (2) run_cycle();
    set_bus(1'b1, 32'h600D_600D);
    r1_start = 1'b0;
    #1;
    chk("t5.r1_done", {31'd0, o_r1_done[0]}, 32'd1);
    chk("t5.r1_q", o_r1_q[0], 32'h600D_600D);
    run_cycle();
    set_bus(1'b0, 32'd0);
    #1 chk("t5.err_sticky", {31'd0, o_err[0]}, 32'd1);

    $display("[TB] reset during BUSY");
    applyStimulus(0, 1'b1, 32'h0000_0700, 32'h7, 1'b1);
    repeat (2) run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    #1;
    chk("t6.bus_start", {31'd0, o_bus_start[0]}, 32'd0);
    chk("t6.r0_done", {31'd0, o_r0_done[0]}, 32'd0);
    chk("t6.err_cleared", {31'd0, o_err[0]}, 32'd0);
    repeat (2) run_cycle();
    set_bus(1'b1, 32'h7777_7777);
    r0_start = 1'b0;
    #1;
    chk("t6.r0_done_after", {31'd0, o_r0_done[0]}, 32'd1);
    chk("t6.r0_q_after", o_r0_q[0], 32'h7777_7777);
    run_cycle();
    set_bus(1'b0, 32'd0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) random_cycle(1'b1, 1'b1);
    reset = 1'b0;
    drain("rand.drain_bound");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
